// File: rtl/seg_scan_driver_if.sv
// Bus bundle between the clock's six segment-pattern outputs and the display scanner.
// SEG_SCAN_BRIGHTNESS_EN adds the i_bright dimming level.
interface seg_scan_driver_if;
    logic [7:0] i_seg0;
    logic [7:0] i_seg1;
    logic [7:0] i_seg2;
    logic [7:0] i_seg3;
    logic [7:0] i_seg4;
    logic [7:0] i_seg5;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [2:0] i_bright;
`endif
    logic [7:0] o_seg;
    logic [5:0] o_dig;
    logic       o_frame;

    modport master (
        output i_seg0, output i_seg1, output i_seg2,
        output i_seg3, output i_seg4, output i_seg5,
`ifdef SEG_SCAN_BRIGHTNESS_EN
        output i_bright,
`endif
        input  o_seg, input o_dig, input o_frame
    );

    modport slave (
        input  i_seg0, input i_seg1, input i_seg2,
        input  i_seg3, input i_seg4, input i_seg5,
`ifdef SEG_SCAN_BRIGHTNESS_EN
        input  i_bright,
`endif
        output o_seg, output o_dig, output o_frame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit time-multiplexed seven-segment scanner with a per-frame input snapshot.
// Optional macro SEG_SCAN_BRIGHTNESS_EN adds frame-latched PWM dimming via i_bright.
module seg_scan_driver #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    seg_scan_driver_if.slave bus
);
    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    shadow_r [0:5];
    logic [7:0]    seg_r;
    logic [5:0]    dig_r;
    logic          frame_r;

    logic [7:0]    in_seg_s [0:5];
    logic [7:0]    cur_seg_s;
    logic [5:0]    cur_dig_s;
    logic          frame_start_s;
    logic          active_s;

    assign in_seg_s[0] = bus.i_seg0;
    assign in_seg_s[1] = bus.i_seg1;
    assign in_seg_s[2] = bus.i_seg2;
    assign in_seg_s[3] = bus.i_seg3;
    assign in_seg_s[4] = bus.i_seg4;
    assign in_seg_s[5] = bus.i_seg5;

    assign frame_start_s = (cnt_r == {CW{1'b0}}) && (idx_r == 3'd0);

    // Digit select and pattern of the current slot; out-of-range idx lights nothing.
    always_comb begin
        cur_seg_s = 8'h00;
        cur_dig_s = 6'b000000;
        case (idx_r)
            3'd0: begin cur_seg_s = shadow_r[0]; cur_dig_s = 6'b000001; end
            3'd1: begin cur_seg_s = shadow_r[1]; cur_dig_s = 6'b000010; end
            3'd2: begin cur_seg_s = shadow_r[2]; cur_dig_s = 6'b000100; end
            3'd3: begin cur_seg_s = shadow_r[3]; cur_dig_s = 6'b001000; end
            3'd4: begin cur_seg_s = shadow_r[4]; cur_dig_s = 6'b010000; end
            3'd5: begin cur_seg_s = shadow_r[5]; cur_dig_s = 6'b100000; end
            default: begin cur_seg_s = 8'h00; cur_dig_s = 6'b000000; end
        endcase
    end

`ifdef SEG_SCAN_BRIGHTNESS_EN
    localparam logic [CW-1:0] CNT_PRE = CW'(BLANK - 1);

    logic [2:0] pwm_r;
    logic [2:0] bright_r;

    // PWM phase restarts so it reads 0 on the first active cycle of every slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_r    <= 3'd0;
            bright_r <= 3'd7;
        end else begin
            if (cnt_r == CNT_PRE) begin
                pwm_r <= 3'd0;
            end else begin
                pwm_r <= pwm_r + 3'd1;
            end
            if (frame_start_s) begin
                bright_r <= bus.i_bright;
            end else begin
                bright_r <= bright_r;
            end
        end
    end

    // Lit only past the blanking gap and within the brightness duty window.
    always_comb begin
        active_s = 1'b0;
        if ((cnt_r >= CNT_BLANK) && (pwm_r <= bright_r)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
    end
`else
    // Lit only past the blanking gap.
    always_comb begin
        active_s = 1'b0;
        if (cnt_r >= CNT_BLANK) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
    end
`endif

    // Scan counters, frame-start snapshot and registered display outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r   <= {CW{1'b0}};
            idx_r   <= 3'd0;
            seg_r   <= 8'h00;
            dig_r   <= 6'b000000;
            frame_r <= 1'b0;
            for (int n = 0; n < 6; n++) begin
                shadow_r[n] <= 8'h00;
            end
        end else begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= {CW{1'b0}};
                idx_r <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
            if (frame_start_s) begin
                for (int n = 0; n < 6; n++) begin
                    shadow_r[n] <= in_seg_s[n];
                end
                frame_r <= 1'b1;
            end else begin
                frame_r <= 1'b0;
            end
            if (active_s) begin
                seg_r <= cur_seg_s;
                dig_r <= cur_dig_s;
            end else begin
                seg_r <= 8'h00;
                dig_r <= 6'b000000;
            end
        end
    end

    assign bus.o_seg   = seg_r;
    assign bus.o_dig   = dig_r;
    assign bus.o_frame = frame_r;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position reference model queues the
// expected outputs per edge, and a monitor compares them one cycle after each edge.
module tb_seg_scan_driver;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    localparam int DIV = 9;
`else
    localparam int DIV = 4;
`endif
    localparam int BLANK = 1;
    localparam int FRAME = 6 * DIV;

    typedef struct packed {
        logic [7:0] seg;
        logic [5:0] dig;
        logic       frame;
        logic       rst;
    } exp_t;

    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] seg_in [6];
    int bright_in = 7;

    int checks = 0;
    int passes = 0;

    // Reference model state: position since last frame start and the latched inputs.
    int m_t = 0;
    logic [7:0] m_snap [6];
    int m_bright = 7;
    logic [5:0] m_last_dig = 6'b0;

    seg_scan_driver_if sif();

    assign sif.i_seg0 = seg_in[0];
    assign sif.i_seg1 = seg_in[1];
    assign sif.i_seg2 = seg_in[2];
    assign sif.i_seg3 = seg_in[3];
    assign sif.i_seg4 = seg_in[4];
    assign sif.i_seg5 = seg_in[5];
`ifdef SEG_SCAN_BRIGHTNESS_EN
    assign sif.i_bright = 3'(bright_in);
`endif

    seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for the coming edge, from the inputs about to be sampled.
    task automatic model_step();
        exp_t e;
        int pos, slot, off;
        e = '0;
        e.rst = rst;
        if (rst) begin
            m_t = 0;
            m_bright = 7;
            for (int n = 0; n < 6; n++) m_snap[n] = 8'h00;
        end else begin
            pos  = m_t % FRAME;
            slot = pos / DIV;
            off  = pos % DIV;
            if (pos == 0) begin
                for (int n = 0; n < 6; n++) m_snap[n] = seg_in[n];
                m_bright = bright_in;
                e.frame = 1'b1;
            end
            if (off >= BLANK && ((off - BLANK) % 8) <= m_bright) begin
                e.dig = 6'(1 << slot);
                e.seg = m_snap[slot];
            end
            m_t++;
        end
        m_last_dig = e.dig;
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        for (int n = 0; n < 6; n++) seg_in[n] = 8'($urandom);
    endtask

    // Monitor: pop and compare, plus display invariants and frame period.
    initial begin
        exp_t e;
        int gap;
        bit gap_ok;
        gap = 0;
        gap_ok = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {17'd0, sif.o_seg, sif.o_dig, sif.o_frame},
                      {17'd0, e.seg, e.dig, e.frame});
                check("invariant", {31'd0, ($countones(sif.o_dig) > 1) ||
                      (sif.o_dig == 6'b0 && sif.o_seg != 8'h00)}, 32'd0);
                gap++;
                if (e.rst) begin
                    gap_ok = 1'b0;
                end else if (sif.o_frame) begin
                    if (gap_ok) check("frame_period", 32'(gap), 32'(FRAME));
                    gap = 0;
                    gap_ok = 1'b1;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        bit hit;
        randomize_inputs();
        rst = 1'b1;
        repeat (3) step();

        seg_in = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
`ifdef SEG_SCAN_BRIGHTNESS_EN
        bright_in = 2;
`endif
        rst = 1'b0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            if (i == DIV + 2) seg_in[2] = 8'h7F;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            if (i == 2 * FRAME + FRAME / 2) bright_in = 7;
            if (i == 5 * FRAME + 7) bright_in = int'($urandom_range(0, 7));
`endif
            if (i >= 2 * FRAME && $urandom_range(0, 7) == 0)
                seg_in[$urandom_range(0, 5)] = 8'($urandom);
            step();
        end

        hit = 1'b0;
        for (int k = 0; k < 2 * FRAME && !hit; k++) begin
            if (m_last_dig == 6'b001000) hit = 1'b1;
            else step();
        end
        check("reach_digit3", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        randomize_inputs();
        repeat (2 * FRAME) step();

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, FRAME)) begin
                if ($urandom_range(0, 9) == 0) randomize_inputs();
`ifdef SEG_SCAN_BRIGHTNESS_EN
                if ($urandom_range(0, 19) == 0) bright_in = int'($urandom_range(0, 7));
`endif
                step();
            end
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            rst = 1'b0;
        end
        repeat (2 * FRAME) step();

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumer end of the clock's six parallel seven-segment buses (seg0 = seconds units … seg5 = hours tens).
- Time-multiplexes the six 8-bit patterns onto one shared segment bus with a one-hot digit select, for a physical 6-digit common-cathode display.
- All six inputs are snapshotted at frame start, so a seconds/minutes rollover never tears mid-frame.
- A blanking gap at the start of every digit slot suppresses ghosting.

Parameters:
- DIV, 1000: clock cycles per digit slot; frame = 6*DIV cycles. Legal: DIV >= 2.
- BLANK, 16: cycles at the start of each slot with all digits off. Legal: 1 <= BLANK < DIV.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_seg0  in  8  pattern for digit 0 (seconds units)
- i_seg1  in  8  pattern for digit 1
- i_seg2  in  8  pattern for digit 2
- i_seg3  in  8  pattern for digit 3
- i_seg4  in  8  pattern for digit 4
- i_seg5  in  8  pattern for digit 5 (hours tens)
- o_seg  out  8  shared segment bus; pattern passed through unmodified
- o_dig  out  6  digit enable, one-hot, active-high; bit n = digit n
- o_frame  out  1  one-cycle pulse marking frame start

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst; sampled only on the rising edge of i_clk.
- State:
  - cnt: 0..DIV-1, width $clog2(DIV).
  - idx: 0..5, 3 bits.
  - shadow[0..5]: 8 bits each.
- Reset values: cnt=0, idx=0, shadow=0, o_seg=0, o_dig=0, o_frame=0.
- cnt and idx advance on every non-reset edge:
  - cnt increments, wrapping DIV-1 -> 0.
  - idx increments when cnt wraps, 5 -> 0.
- All outputs are registered and reflect the (cnt, idx) state at the preceding edge (1-cycle latency).
- Edge with cnt==0 and idx==0:
  - shadow[n] <= i_segn for all n.
  - o_frame <= 1.
- All other edges: o_frame <= 0.
- Edge with cnt < BLANK: o_dig <= 0, o_seg <= 0 (blank).
- Edge with cnt >= BLANK: o_dig <= 1<<idx, o_seg <= shadow[idx].
  - BLANK >= 1 guarantees shadow is already updated before digit 0 is read.
- Invariants:
  - o_dig has at most one bit set.
  - o_seg == 0 whenever o_dig == 0.
- Timing, with T0 = first rising edge where i_rst=0:
  - o_frame is high in the cycle after T0, then every 6*DIV cycles.
  - Each digit is lit for DIV-BLANK consecutive cycles per frame.
- Inputs are sampled only at frame start; changes elsewhere in the frame are ignored until the next frame.
- Reset mid-frame: all outputs are 0 on the cycle after the reset edge. The scan restarts at digit 0 with a fresh snapshot and an o_frame pulse after reset release.
- No handshake; the inputs are level-held buses from the clock.

Optional Feature:
- Macro: SEG_SCAN_BRIGHTNESS_EN.
- Defined:
  - Adds input port i_bright, 3 bits, placed after i_seg5.
  - i_bright is latched into bright_q at frame start, alongside shadow.
  - A 3-bit pwm counter is 0 at the first active cycle of each slot (cnt==BLANK) and increments each cycle, wrapping.
  - The active-cycle rule applies only when pwm <= bright_q; otherwise o_dig=0, o_seg=0.
  - bright_q=7 gives full on; 0 gives 1/8 duty.
  - Reset value: bright_q=7.
- Not defined: no i_bright port, no pwm logic; full-brightness behaviour as above.

Test Plan:
- Reset: DIV=4, BLANK=1; hold i_rst for 3 cycles -> o_seg=0x00, o_dig=6'b0, o_frame=0 throughout.
- Scan order: i_seg0..5 = 0x3F,0x06,0x5B,0x4F,0x66,0x6D; release reset.
  - o_frame=1 for one cycle.
  - Then per slot: 1 blank cycle (o_dig=0, o_seg=0), then 3 cycles of o_dig=000001/0x3F, 000010/0x06, … 100000/0x6D.
  - Sequence repeats.
- Snapshot: during digit 1 of frame 0, change i_seg2 to 0x7F.
  - Digit 2 still shows 0x5B in frame 0.
  - Shows 0x7F from frame 1.
- Period and invariants: run 10 frames.
  - o_frame pulses exactly every 24 cycles.
  - popcount(o_dig) <= 1 every cycle; o_seg==0 whenever o_dig==0.
- Mid-frame reset: assert i_rst for 1 cycle while o_dig=001000.
  - Next cycle all outputs are 0.
  - After release: o_frame pulse, then digit 0 with the current inputs.
- Brightness (macro defined): DIV=9, BLANK=1.
  - i_bright=2: each slot = 1 blank cycle, 3 lit, 5 dark.
  - i_bright=7: 8 lit.
  - Change i_bright mid-frame: duty changes only after the next o_frame.
